// File: rtl/s38584_n1243_state_wrap.sv
// s38584_n1243_state_wrap
//
// Sequential slice wrapped around the combinational n1243 cone. Holds the
// 20 pseudo-primary state bits that feed the cone and, during RUN, registers
// the cone output n1243 back into g671. State is loaded and unloaded through
// a serial scan chain, so the slice can be compared against the full netlist.
//
// Ports
//   CK          clock, everything on the rising edge
//   RST         synchronous active-high reset
//   start       one-cycle request, only honoured in IDLE
//   run_len     number of functional cycles, captured on an accepted start
//   scan_in     serial load data
//   n1243       next-state value of g671 from the cone, used only in RUN
//   g671..g376  state bits st[0]..st[19] driving the cone
//   scan_out    serial unload data, always st[19]
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
//   toggle_cnt  saturating count of g671 changes during RUN
//   fsm_state   current FSM state, for observation only
//
// Handshake: start is accepted only on a rising edge where the FSM is IDLE
// (busy=0) and RST=0; busy rises on the following cycle and stays high until
// the cycle after done. start while busy is dropped, never queued. done is
// high for exactly one cycle, 20 + run_len + 20 + 1 cycles after acceptance.

module s38584_n1243_state_wrap #(
   parameter int NBITS = 20,  // chain order below is fixed, only 20 is supported
   parameter int CNTW  = 8
) (
   input  logic            CK,
   input  logic            RST,
   input  logic            start,
   input  logic [CNTW-1:0] run_len,
   input  logic            scan_in,
   input  logic            n1243,
   output logic            g671,
   output logic            g703,
   output logic            g676,
   output logic            g504,
   output logic            g499,
   output logic            g650,
   output logic            g661,
   output logic            g728,
   output logic            g718,
   output logic            g655,
   output logic            g645,
   output logic            g528,
   output logic            g681,
   output logic            g699,
   output logic            g490,
   output logic            g482,
   output logic            g385,
   output logic            g358,
   output logic            g370,
   output logic            g376,
   output logic            scan_out,
   output logic            busy,
   output logic            done,
   output logic [CNTW-1:0] toggle_cnt,
   output logic [2:0]      fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_RUN    = 3'd2,
      S_UNLOAD = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // The shared counter tracks both shift positions (0..NBITS-1) and run
   // cycles (0..rl-1), so it is CNTW wide; CNTW must cover NBITS-1.
   localparam logic [CNTW-1:0] LAST_SHIFT = CNTW'(NBITS - 1);
   localparam logic [CNTW-1:0] TOG_MAX    = {CNTW{1'b1}};

   state_t           state;
   logic [NBITS-1:0] st;
   logic [CNTW-1:0]  rl;
   logic [CNTW-1:0]  cnt;

   always_ff @(posedge CK) begin
      if (RST) begin
         state      <= S_IDLE;
         st         <= '0;
         rl         <= '0;
         cnt        <= '0;
         toggle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  rl         <= run_len;
                  toggle_cnt <= '0;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               // First bit in travels all the way up to st[19].
               st <= {st[NBITS-2:0], scan_in};
               if (cnt == LAST_SHIFT) begin
                  cnt   <= '0;
                  state <= (rl != '0) ? S_RUN : S_UNLOAD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
               st[0] <= n1243;
               if ((n1243 != st[0]) && (toggle_cnt != TOG_MAX))
                  toggle_cnt <= toggle_cnt + 1'b1;
               // rl is non-zero here, LOAD skips RUN otherwise.
               if (cnt == rl - 1'b1) begin
                  cnt   <= '0;
                  state <= S_UNLOAD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_UNLOAD: begin
               st <= {st[NBITS-2:0], 1'b0};
               if (cnt == LAST_SHIFT) begin
                  cnt   <= '0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign g671 = st[0];
   assign g703 = st[1];
   assign g676 = st[2];
   assign g504 = st[3];
   assign g499 = st[4];
   assign g650 = st[5];
   assign g661 = st[6];
   assign g728 = st[7];
   assign g718 = st[8];
   assign g655 = st[9];
   assign g645 = st[10];
   assign g528 = st[11];
   assign g681 = st[12];
   assign g699 = st[13];
   assign g490 = st[14];
   assign g482 = st[15];
   assign g385 = st[16];
   assign g358 = st[17];
   assign g370 = st[18];
   assign g376 = st[19];

   assign scan_out  = st[NBITS-1];
   assign fsm_state = state;

endmodule

// File: tb/tb_s38584_n1243_state_wrap.sv
// tb_s38584_n1243_state_wrap
//
// Driver issues load/run/unload transactions and pushes the reference
// model's result ({latency, toggle count, state before unload}) onto exp_q.
// An independent monitor keeps the last 20 scan_out samples and, whenever
// done is seen, pops and compares.

module tb_s38584_n1243_state_wrap;

   logic       CK;
   logic       RST;
   logic       start;
   logic [7:0] run_len;
   logic       scan_in;
   logic       n1243;
   logic       g671, g703, g676, g504, g499, g650, g661, g728, g718, g655;
   logic       g645, g528, g681, g699, g490, g482, g385, g358, g370, g376;
   logic       scan_out;
   logic       busy;
   logic       done;
   logic [7:0] toggle_cnt;
   logic [2:0] fsm_state;

   logic [19:0] st_obs;
   assign st_obs = {g376, g370, g358, g385, g482, g490, g699, g681, g528, g645,
                    g655, g718, g728, g661, g650, g499, g504, g676, g703, g671};

   s38584_n1243_state_wrap dut (
      .CK(CK), .RST(RST), .start(start), .run_len(run_len),
      .scan_in(scan_in), .n1243(n1243),
      .g671(g671), .g703(g703), .g676(g676), .g504(g504), .g499(g499),
      .g650(g650), .g661(g661), .g728(g728), .g718(g718), .g655(g655),
      .g645(g645), .g528(g528), .g681(g681), .g699(g699), .g490(g490),
      .g482(g482), .g385(g385), .g358(g358), .g370(g370), .g376(g376),
      .scan_out(scan_out), .busy(busy), .done(done),
      .toggle_cnt(toggle_cnt), .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial CK = 1'b0;
   always #5 CK = ~CK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int acc_cyc  = 0;
   int last_tog = 0;

   // {latency[15:0], toggle[7:0], state before unload[19:0]}
   logic [43:0] exp_q[$];

   initial forever begin
      @(posedge CK);
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400 && busy; i++) tick();
      check("idle_timeout", 64'(busy), 64'(0));
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [19:0] hist;
      logic [43:0] e;
      hist = '0;
      forever begin
         @(negedge CK);
         if (RST) begin
            hist = '0;
         end else begin
            if (done) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL spurious_done: got done=1 required no pending transaction (t=%0t)", $time);
               end else begin
                  e = exp_q.pop_front();
                  check("unload_bits", 64'(hist), 64'(e[19:0]));
                  check("toggle_cnt", 64'(toggle_cnt), 64'(e[27:20]));
                  check("latency", 64'(cyc - acc_cyc), 64'(e[43:28]));
               end
            end
            if (start && !busy) acc_cyc = cyc;
            // Oldest of the last 20 samples lands in bit 19, matching st order.
            hist = {hist[18:0], scan_out};
         end
      end
   end

   // ---------------- driver ----------------
   // ld[k] is the scan_in bit of load cycle k; nseq[i] the n1243 of run cycle i.
   task automatic run_txn(input logic [19:0] ld, input int rl,
                          input logic [254:0] nseq, input bit poke);
      logic [19:0] m;
      logic [19:0] m_load;
      int          tog;
      m = '0;
      for (int k = 0; k < 20; k++) m[19-k] = ld[k];
      m_load = m;
      tog = 0;
      for (int i = 0; i < rl; i++) begin
         if (nseq[i] != m[0]) tog = (tog < 255) ? tog + 1 : 255;
         m[0] = nseq[i];
      end
      wait_idle();
      exp_q.push_back({16'(41 + rl), 8'(tog), m});

      start   = 1'b1;
      run_len = 8'(rl);
      scan_in = 1'($urandom);
      n1243   = 1'($urandom);
      tick();
      start   = 1'b0;
      scan_in = ld[0];
      for (int k = 1; k < 20; k++) begin
         tick();
         scan_in = ld[k];
         n1243   = 1'($urandom);
         start   = (poke && k == 7);
      end
      tick();
      start = 1'b0;
      check("after_load_st", 64'(st_obs), 64'(m_load));
      check("busy_in_txn", 64'(busy), 64'(1));
      for (int i = 0; i < rl; i++) begin
         n1243   = nseq[i];
         scan_in = 1'($urandom);
         tick();
         check("run_g671", 64'(g671), 64'(nseq[i]));
      end
      for (int u = 0; u < 20; u++) begin
         start   = (poke && u == 10);
         scan_in = 1'($urandom);
         n1243   = 1'($urandom);
         tick();
      end
      start = 1'b0;
      tick();
      wait_idle();
      check("idle_st_clear", 64'({scan_out, st_obs}), 64'(0));
      last_tog = tog;
   endtask

   initial begin : stimulus
      logic [254:0] nseq;
      RST = 1'b1; start = 1'b0; run_len = '0; scan_in = 1'b0; n1243 = 1'b0;
      repeat (3) @(posedge CK);
      #1;
      RST = 1'b0;
      check("reset_state", 64'({busy, done, toggle_cnt, scan_out, st_obs}), 64'(0));

      // Load pattern 1,0x18,1 with no run, extra starts during LOAD/UNLOAD.
      nseq = '0;
      run_txn(20'h80001, 0, nseq, 1'b1);

      // Run capture: n1243 = 1,0,1,1 onto an all-zero state.
      nseq = '0;
      nseq[0] = 1'b1; nseq[2] = 1'b1; nseq[3] = 1'b1;
      run_txn(20'h00000, 4, nseq, 1'b0);

      // Hold in IDLE while inputs wiggle.
      for (int i = 0; i < 50; i++) begin
         n1243   = 1'($urandom);
         scan_in = 1'($urandom);
         tick();
         check("idle_hold", 64'({busy, toggle_cnt, st_obs}), 64'({1'b0, 8'(last_tog), 20'h0}));
      end

      // Saturation: 255 alternating cycles.
      for (int i = 0; i < 255; i++) nseq[i] = (i % 2 == 0);
      run_txn(20'h00000, 255, nseq, 1'b0);

      // Reset in the middle of RUN, with a start in the same cycle as RST.
      wait_idle();
      start = 1'b1; run_len = 8'd10;
      tick();
      start = 1'b0;
      n1243 = 1'b1;
      repeat (23) begin
         scan_in = 1'($urandom);
         tick();
      end
      RST = 1'b1;
      start = 1'b1;
      tick();
      RST = 1'b0;
      start = 1'b0;
      check("midrun_reset", 64'({busy, done, toggle_cnt, scan_out, st_obs}), 64'(0));
      tick();
      check("start_with_rst_dropped", 64'(busy), 64'(0));

      // Randomized transactions.
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 255; i++) nseq[i] = 1'($urandom);
         run_txn(20'($urandom), int'($urandom_range(0, 20)), nseq, 1'($urandom));
      end

      repeat (5) tick();
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
